stack_ctrl: RTL and testbench

//  Two-requester stack access controller for the data/return stack of the simple CPU.

---
 rtl/stack_ctrl_pkg.sv | 16 +
 rtl/stack_ctrl_rr_arb.sv | 44 ++++
 rtl/stack_ctrl.sv | 143 ++++++++++++++
 tb/tb_stack_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared types and constants for the stack access controller.
package stack_ctrl_pkg;

  localparam int NREQ = 2;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_ctrl_rr_arb.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins. last_q remembers the most recent grant and resets to 1, so
// requester 0 wins the first tie.
import stack_ctrl_pkg::*;

module stack_ctrl_rr_arb (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic            last_q
);

  logic last_d;

  // One-hot grant: a lone requester always wins, a tie goes to the non-last one
  always_comb begin
    grant = '0;
    if (req[0] && req[1]) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Move the pointer only when the controller actually takes the grant
  always_comb begin
    last_d = last_q;
    if (advance && (grant != '0)) begin
      last_d = grant[1];
    end
  end

  // Last-grant pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack access controller: arbitrates two push/pop requesters, owns the
// downward-growing stack pointer and depth, and sequences a single-port
// synchronous RAM with one cycle of read latency.
// Optional feature macro: STACK_CTRL_BOUNDS_EN rejects pushes when full and
// pops when empty, reporting them with err alongside ack.
import stack_ctrl_pkg::*;

module stack_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_pop,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]         ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH:0]     depth,
  output logic                    full,
  output logic                    empty
);

  localparam logic [ADDR_WIDTH:0] FULL_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rej_q, rej_d;
  logic [NREQ-1:0]       grant;
  logic                  advance;
  logic                  gnt_idx;

  // gnt_idx doubles as "who is being served": it is updated on the grant edge
  stack_ctrl_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .last_q  (gnt_idx)
  );

  assign depth = depth_q;
  assign full  = (depth_q == FULL_DEPTH);
  assign empty = (depth_q == '0);

  // FSM next state, pointer/depth updates and RAM/requester outputs
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    depth_d   = depth_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    rej_d     = rej_q;
    advance   = 1'b0;
    ack       = '0;
    rdata     = '0;
    err       = 1'b0;
    mem_addr  = sp_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid != '0) begin
          advance = 1'b1;
          op_d    = req_pop[grant[1]];
          wdata_d = grant[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                             : req_wdata[DATA_WIDTH-1:0];
`ifdef STACK_CTRL_BOUNDS_EN
          rej_d   = (req_pop[grant[1]] == OP_POP) ? empty : full;
`else
          rej_d   = 1'b0;
`endif
          state_d = (req_pop[grant[1]] == OP_POP) ? READ : WRITE;
        end else if (flush) begin
          sp_d    = '1;
          depth_d = '0;
        end
      end
      WRITE: begin
        ack[gnt_idx] = 1'b1;
        err          = rej_q;
        if (!rej_q) begin
          mem_we = 1'b1;
          sp_d   = sp_q - 1'b1;
          if (depth_q != FULL_DEPTH) begin
            depth_d = depth_q + 1'b1;
          end
        end
        state_d = IDLE;
      end
      READ: begin
        mem_addr = sp_q + 1'b1;
        if (!rej_q) begin
          mem_re = 1'b1;
          sp_d   = sp_q + 1'b1;
          if (depth_q != '0) begin
            depth_d = depth_q - 1'b1;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        ack[gnt_idx] = 1'b1;
        err          = rej_q;
        rdata        = rej_q ? '0 : mem_rdata;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and latched-request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sp_q    <= '1;
      depth_q <= '0;
      op_q    <= OP_PUSH;
      wdata_q <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rej_q   <= rej_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl (ADDR_WIDTH=3, DATA_WIDTH=8).
// Honours STACK_CTRL_BOUNDS_EN the same way the design does.
module tb_stack_ctrl;

`ifdef STACK_CTRL_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_pop;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        err;
  logic [2:0]  mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [3:0]  depth;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ram [8] = '{default: 8'h00};

  // Behavioural model: stack pointer, depth and RAM image
  logic [2:0] msp = 3'd7;
  int         mdepth = 0;
  logic [7:0] mmem [8] = '{default: 8'h00};
  logic       pend_op [2] = '{1'b0, 1'b0};
  logic [7:0] pend_data [2] = '{8'h00, 8'h00};
  int         m_r;
  logic       m_rej;
  logic [7:0] m_exp;

  // Captured results of the most recent transaction
  int         lat;
  int         first;
  logic [7:0] gd;
  logic       ge;
  logic [2:0] ga;
  logic       gw;
  logic [2:0] gra;

  stack_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_pop   (req_pop),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the stack model
  always @(negedge clk) begin
    if (!rst) begin
      msp    = 3'd7;
      mdepth = 0;
    end else begin
      if (flush && req_valid == 2'b00) begin
        msp    = 3'd7;
        mdepth = 0;
      end
      if (mem_re) checkOutput("read_addr", 32'(mem_addr), 32'(3'(msp + 3'd1)));
      if (ack != 2'b00) begin
        checkOutput("ack_onehot", 32'(ack == 2'b11), 32'd0);
        m_r = ack[1] ? 1 : 0;
        if (pend_op[m_r] == 1'b0) begin
          m_rej = BOUNDS && (mdepth == 8);
          checkOutput("push_err", 32'(err), 32'(m_rej));
          checkOutput("push_we", 32'(mem_we), 32'(!m_rej));
          checkOutput("push_depth", 32'(depth), 32'(mdepth));
          checkOutput("push_full", 32'(full), 32'(mdepth == 8));
          if (!m_rej) begin
            checkOutput("push_addr", 32'(mem_addr), 32'(msp));
            checkOutput("push_wdata", 32'(mem_wdata), 32'(pend_data[m_r]));
            mmem[msp] = pend_data[m_r];
            msp = msp - 3'd1;
            if (mdepth < 8) mdepth++;
          end
        end else begin
          m_rej = BOUNDS && (mdepth == 0);
          m_exp = m_rej ? 8'h00 : mmem[3'(msp + 3'd1)];
          checkOutput("pop_err", 32'(err), 32'(m_rej));
          checkOutput("pop_rdata", 32'(rdata), 32'(m_exp));
          if (!m_rej) begin
            msp = msp + 3'd1;
            if (mdepth > 0) mdepth--;
          end
          checkOutput("pop_depth", 32'(depth), 32'(mdepth));
          checkOutput("pop_empty", 32'(empty), 32'(mdepth == 0));
        end
      end else begin
        checkOutput("idle_err", 32'(err), 32'd0);
        checkOutput("idle_rdata", 32'(rdata), 32'd0);
        checkOutput("idle_we", 32'(mem_we), 32'd0);
      end
    end
  end

  // One request from requester r; waits (bounded) for its ack
  task automatic applyStimulus(input int r, input logic pop, input logic [7:0] d);
    int  start;
    bit  done;
    done = 1'b0;
    gra  = 3'd0;
    @(negedge clk);
    #1;
    pend_op[r]         = pop;
    pend_data[r]       = d;
    req_pop[r]         = pop;
    req_wdata[r*8 +: 8] = d;
    req_valid[r]       = 1'b1;
    start              = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_re) gra = mem_addr;
      if (ack[r]) begin
        gd   = rdata;
        ge   = err;
        ga   = mem_addr;
        gw   = mem_we;
        lat  = cyc - start;
        done = 1'b1;
        break;
      end
    end
    req_valid[r] = 1'b0;
    if (!done) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  // Both requesters push in the same cycle; reports who was acked first
  task automatic applyPair(input logic [7:0] d0, input logic [7:0] d1);
    bit done0;
    bit done1;
    done0 = 1'b0;
    done1 = 1'b0;
    first = -1;
    @(negedge clk);
    #1;
    pend_op[0]   = 1'b0;
    pend_op[1]   = 1'b0;
    pend_data[0] = d0;
    pend_data[1] = d1;
    req_pop      = 2'b00;
    req_wdata    = {d1, d0};
    req_valid    = 2'b11;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack[0] && !done0) begin
        done0 = 1'b1;
        req_valid[0] = 1'b0;
        if (first < 0) first = 0;
      end
      if (ack[1] && !done1) begin
        done1 = 1'b1;
        req_valid[1] = 1'b0;
        if (first < 0) first = 1;
      end
      if (done0 && done1) break;
    end
    if (!(done0 && done1)) checkOutput("pair_timeout", 32'd0, 32'd1);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    flush     = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b00;
    req_pop   = 2'b00;
    req_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    resetDut();
    checkOutput("rst_depth", 32'(depth), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_strobes", 32'({mem_we, mem_re}), 32'd0);

    // First push lands at address 7 one cycle after the grant
    applyStimulus(0, 1'b0, 8'hA5);
    checkOutput("t1_latency", 32'(lat), 32'd1);
    checkOutput("t1_addr", 32'(ga), 32'd7);
    checkOutput("t1_we", 32'(gw), 32'd1);
    @(negedge clk);
    checkOutput("t1_depth", 32'(depth), 32'd1);

    // Push, push, pop returns the last pushed word from address 6
    resetDut();
    applyStimulus(0, 1'b0, 8'h11);
    applyStimulus(0, 1'b0, 8'h22);
    applyStimulus(0, 1'b1, 8'h00);
    checkOutput("t2_latency", 32'(lat), 32'd2);
    checkOutput("t2_read_addr", 32'(gra), 32'd6);
    checkOutput("t2_rdata", 32'(gd), 32'h22);
    @(negedge clk);
    checkOutput("t2_depth", 32'(depth), 32'd1);

    // Simultaneous requests: req0 first after reset, then rotation
    resetDut();
    applyPair(8'h30, 8'h31);
    checkOutput("t3_first_after_reset", 32'(first), 32'd0);
    applyStimulus(0, 1'b0, 8'h32);
    applyPair(8'h33, 8'h34);
    checkOutput("t3_first_rotated", 32'(first), 32'd1);

    // Fill to capacity, then one more push
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, 8'h40 + 8'(i));
    @(negedge clk);
    checkOutput("t4_full", 32'(full), 32'd1);
    checkOutput("t4_depth", 32'(depth), 32'd8);
    applyStimulus(1, 1'b0, 8'h99);
`ifdef STACK_CTRL_BOUNDS_EN
    checkOutput("t4_over_err", 32'(ge), 32'd1);
    checkOutput("t4_over_we", 32'(gw), 32'd0);
`else
    checkOutput("t4_over_addr", 32'(ga), 32'd7);
    checkOutput("t4_over_we", 32'(gw), 32'd1);
`endif
    @(negedge clk);
    checkOutput("t4_depth_after", 32'(depth), 32'd8);

    // Pop on empty
    resetDut();
    applyStimulus(1, 1'b1, 8'h00);
    checkOutput("t5_latency", 32'(lat), 32'd2);
`ifdef STACK_CTRL_BOUNDS_EN
    checkOutput("t5_rdata", 32'(gd), 32'd0);
    checkOutput("t5_err", 32'(ge), 32'd1);
    applyStimulus(0, 1'b0, 8'h55);
    checkOutput("t5_next_push_addr", 32'(ga), 32'd7);
`else
    checkOutput("t5_read_addr", 32'(gra), 32'd0);
    @(negedge clk);
    checkOutput("t5_depth", 32'(depth), 32'd0);
    applyStimulus(0, 1'b0, 8'h55);
    checkOutput("t5_next_push_addr", 32'(ga), 32'd0);
`endif

    // Reset while a pop is in its READ cycle: no ack, pointer restored
    resetDut();
    applyStimulus(0, 1'b0, 8'h66);
    @(negedge clk);
    #1;
    pend_op[0]   = 1'b1;
    req_pop[0]   = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    checkOutput("t6_in_read", 32'(mem_re), 32'd1);
    #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    #1;
    checkOutput("t6_re_async_drop", 32'(mem_re), 32'd0);
    checkOutput("t6_no_ack", 32'(ack), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_depth", 32'(depth), 32'd0);
    checkOutput("t6_empty", 32'(empty), 32'd1);
    applyStimulus(0, 1'b0, 8'h77);
    checkOutput("t6_push_addr", 32'(ga), 32'd7);

    // Flush in IDLE after three pushes
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 8'h80 + 8'(i));
    @(negedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    checkOutput("t6_flush_depth", 32'(depth), 32'd0);
    checkOutput("t6_flush_empty", 32'(empty), 32'd1);
    applyStimulus(0, 1'b0, 8'h88);
    checkOutput("t6_flush_push_addr", 32'(ga), 32'd7);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
